imem_loader: RTL

- Boot-time program loader upstream of the single-cycle RV32 core.
- Accepts a byte stream (UART RX / testbench) with valid/ready handshake.
- Assembles little-endian 32-bit instruction words and writes them into core instruction memory via `insMemEn`/`insMemAddr`/`insMemData`.
- Holds the core in reset until the image is complete, then releases it.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_byte_assembler.sv | 50 +++++
 rtl/imem_loader.sv | 128 ++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int COUNT_BYTES    = 2;
  localparam int WORD_BITS      = BYTES_PER_WORD * 8;

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CHK,
    S_RUN,
    S_ERR
  } state_t;

endpackage

// File: rtl/imem_byte_assembler.sv
// Packs a little-endian byte stream into 32-bit words and emits a one-cycle
// registered pulse with the finished word after every fourth byte.
module imem_byte_assembler
  import imem_loader_pkg::*;
(
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic                 i_byte_valid,
  input  logic [7:0]           i_byte_data,
  output logic                 o_word_last,
  output logic                 o_word_valid,
  output logic [WORD_BITS-1:0] o_word
);

  logic [1:0]           r_cnt;
  logic [WORD_BITS-1:0] r_shift;
  logic [WORD_BITS-1:0] r_word;
  logic                 r_word_valid;
  logic [WORD_BITS-1:0] w_shift_next;

  // New bytes enter at the top so the first byte ends up in bits [7:0].
  assign w_shift_next = {i_byte_data, r_shift[WORD_BITS-1:8]};
  assign o_word_last  = i_byte_valid && (r_cnt == 2'(BYTES_PER_WORD - 1));
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt        <= '0;
      r_shift      <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else if (i_clear) begin
      r_cnt        <= '0;
      r_shift      <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= o_word_last;
      if (i_byte_valid) begin
        r_cnt   <= r_cnt + 2'd1;
        r_shift <= w_shift_next;
        if (o_word_last) begin
          r_word <= w_shift_next;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> instruction-memory writes, core held
// in reset until the image is in. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  input  logic             reload,
  output logic             insMemEn,
  output logic [WIDTH-1:0] insMemAddr,
  output logic [WIDTH-1:0] insMemData,
  output logic             cpuReset,
  output logic             done,
  output logic             error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_AFTER_DATA = S_CHK;
  logic [7:0] r_xor;
`else
  localparam state_t S_AFTER_DATA = S_RUN;
`endif

  state_t                   r_state;
  state_t                   w_state_next;
  logic [COUNT_BYTES*8-1:0] r_count;
  logic [COUNT_BYTES*8-1:0] r_index;
  logic [COUNT_BYTES*8-1:0] w_count_full;
  logic [WIDTH-1:0]         r_addr;
  logic                     r_cpu_reset;
  logic                     r_done;
  logic                     r_error;
  logic                     w_take;
  logic                     w_reload;
  logic                     w_word_last;
  logic                     w_word_valid;
  logic [WORD_BITS-1:0]     w_word;
  logic                     w_run_stays;

  assign in_ready     = !reset && (r_state inside {S_LEN0, S_LEN1, S_DATA, S_CHK});
  assign w_take       = in_valid && in_ready;
  assign w_reload     = reload && (r_state == S_RUN || r_state == S_ERR);
  assign w_count_full = {in_data, r_count[7:0]};
  // Running outputs come one cycle after entering S_RUN so the last write lands first.
  assign w_run_stays  = (r_state == S_RUN) && (w_state_next == S_RUN);

  imem_byte_assembler u_asm (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_clear      (w_reload),
    .i_byte_valid (w_take && (r_state == S_DATA)),
    .i_byte_data  (in_data),
    .o_word_last  (w_word_last),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_LEN0: if (w_take) w_state_next = S_LEN1;
      S_LEN1: begin
        if (w_take) begin
          if (w_count_full > 16'(DEPTH))  w_state_next = S_ERR;
          else if (w_count_full == 16'd0) w_state_next = S_AFTER_DATA;
          else                            w_state_next = S_DATA;
        end
      end
      S_DATA: if (w_word_last && (r_index == r_count - 16'd1)) w_state_next = S_AFTER_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK:  if (w_take) w_state_next = (in_data == r_xor) ? S_RUN : S_ERR;
`else
      S_CHK:  w_state_next = S_ERR;
`endif
      S_RUN, S_ERR: if (w_reload) w_state_next = S_LEN0;
      default: w_state_next = S_LEN0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_LEN0;
      r_count     <= '0;
      r_index     <= '0;
      r_addr      <= '0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_done      <= w_run_stays;
      r_cpu_reset <= !w_run_stays;
      r_error     <= (w_state_next == S_ERR);
      if (w_take && r_state == S_LEN0) r_count[7:0] <= in_data;
      if (w_take && r_state == S_LEN1) r_count <= w_count_full;
      if (w_reload) begin
        r_index <= '0;
      end else if (w_word_last) begin
        r_addr  <= WIDTH'(r_index);
        r_index <= r_index + 16'd1;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (reset || w_reload) begin
      r_xor <= '0;
    end else if (w_take && r_state != S_CHK) begin
      r_xor <= r_xor ^ in_data;
    end
  end
`endif

  assign insMemEn   = w_word_valid;
  assign insMemAddr = r_addr;
  assign insMemData = WIDTH'(w_word);
  assign cpuReset   = r_cpu_reset;
  assign done       = r_done;
  assign error      = r_error;

endmodule
